pe_sad_acc: RTL and testbench
=============================

// Module: pe_sad_acc
// PURPOSE
//  Parametrised motion-estimation processing element; successor of the 4-neighbour PE.
//  Holds NUM_CB current-block pixel banks and one reference pixel loaded from four neighbour taps.
//  Computes a registered |cur - ref| and accumulates BLK_PIX differences into a SAD with a done pulse.
//  Sits in the ME systolic array: one instance per array cell. The SAD feeds the best-match compare tree.
// PARAMETERS
//  PIXEL_W   8   pixel width in bits
//  NUM_CB    2   number of current-block banks; must be a power of 2, >= 2
//  CB_SEL_W  1   bank select width, = log2(NUM_CB)
//  BLK_PIX   64  differences per SAD; must be >= 2
//  ACC_W     16  accumulator width; must be >= PIXEL_W + log2(BLK_PIX)
// PORTS
//  clk          in   1                 clock, rising edge
//  rst          in   1                 asynchronous, active-high reset
//  cur_in       in   PIXEL_W           current pixel write data
//  cur_wr_en    in   1                 write cur_in into bank cur_wr_bank
//  cur_wr_bank  in   CB_SEL_W          target bank for the write
//  cb_select    in   CB_SEL_W          bank used for the difference
//  ref_up_1     in   PIXEL_W           upper neighbour tap, distance 1
//  ref_up_s     in   PIXEL_W           upper neighbour tap, row stride
//  ref_dn_1     in   PIXEL_W           lower neighbour tap, distance 1
//  ref_dn_s     in   PIXEL_W           lower neighbour tap, row stride
//  ref_ld       in   1                 load the reference register
//  ref_sel      in   2                 00 up_1, 01 up_s, 10 dn_1, 11 dn_s
//  abs_mask     in   1                 force this cell's difference to 0
//  acc_start    in   1                 begin a new SAD
//  in_valid     in   1                 a difference is requested this cycle
//  next_cur     out  NUM_CB*PIXEL_W    all banks; bank i is in bits [i*PIXEL_W +: PIXEL_W]
//  ref_pix      out  PIXEL_W           reference register; chains to neighbour cells
//  abs_out      out  PIXEL_W           registered absolute difference
//  sad_out      out  ACC_W             final SAD; holds until the next done
//  sad_valid    out  1                 one-cycle pulse when sad_out updates
//  busy         out  1                 high while the FSM is in ACCUM
//  sad_sat      out  1                 SAD saturated (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all banks, ref_pix, abs_out, sad_out, accumulator and count go to 0.
//    sad_valid, busy and sad_sat go to 0; the FSM goes to IDLE. Applies mid-SAD; a partial SAD is dropped.
//  - Bank write: on cur_wr_en, bank[cur_wr_bank] <= cur_in at the edge.
//    A difference in the same cycle uses the pre-write bank value.
//  - Reference load: on ref_ld, ref_pix <= the tap selected by ref_sel; otherwise ref_pix holds.
//    A difference in the same cycle uses the old ref_pix.
//  - Stage 1: if in_valid, abs_out <= abs_mask ? 0 : |bank[cb_select] - ref_pix|, and abs_v <= 1.
//    If not in_valid, abs_out holds and abs_v <= 0. The difference is unsigned and PIXEL_W+1 bits internally.
//    Stage 1 runs in every FSM state.
//  - FSM states: IDLE and ACCUM.
//    IDLE: on acc_start, go to ACCUM with acc=0 and cnt=0; abs_v in IDLE is discarded.
//    ACCUM: on abs_v, acc += abs_out and cnt++.
//    When abs_v arrives with cnt==BLK_PIX-1: sad_out <= acc+abs_out, sad_valid=1 for one cycle, acc=0, go to IDLE.
//  - Latency: in_valid of the last pixel at edge k gives sad_valid high after edge k+1, i.e. 2 cycles.
//  - acc_start in ACCUM restarts: acc=0, cnt=0, and an abs_v in that cycle is discarded. No sad_valid is issued.
//  - acc_start in the same cycle as the final-pixel abs_v: the restart wins; no sad_valid; the FSM stays in ACCUM.
//  - busy = (state == ACCUM). Gaps in in_valid are allowed; the count advances only on abs_v.
// CONFIGURATION
//  Macro PE_SAD_SAT_EN.
//  - Defined: the accumulator saturates at 2^ACC_W-1.
//    sad_sat is set on the first clip and stays set until acc_start or rst; sad_out is reported clipped.
//  - Undefined: the accumulator wraps modulo 2^ACC_W and sad_sat is tied to 0.
// TESTING
//  1. Assert rst mid-SAD -> all outputs 0 immediately (asynchronous); busy=0; a new acc_start works normally.
//  2. bank0=0x0F, bank1=0x07, cb_select=0, ref_ld with ref_sel=00 and ref_up_1=0x01, then in_valid
//     -> ref_pix=0x01 and abs_out=0x0E. With cb_select=1 -> abs_out=0x06.
//     Then ref_sel=11 with ref_dn_s=0x20 -> abs_out=0x19.
//  3. BLK_PIX=4; acc_start, then 4 in_valid with differences 3,5,0,9 (one idle gap between pixels)
//     -> sad_out=17 and sad_valid one cycle, 2 cycles after the last in_valid; busy drops.
//  4. acc_start after 2 of 4 pixels, then 4 pixels of difference 1
//     -> sad_out=4; no sad_valid before that. abs_mask on all 4 pixels -> sad_out=0.
//  5. Same-cycle write and ref_ld alongside in_valid -> abs_out uses the old values; the next difference uses the new ones.
//  6. ACC_W=9, PIXEL_W=8, BLK_PIX=4, all differences 255
//     -> with the macro: sad_out=511 and sad_sat=1. Without it: sad_out=1020 mod 512 = 508 and sad_sat=0.

Source files
------------

// File: rtl/pe_sad_acc_if.sv
// Pixel, control and result bundle for one motion-estimation SAD cell.
// master drives writes/taps/control; slave is the pe_sad_acc cell.
interface pe_sad_acc_if #(
    parameter int unsigned PIXEL_W  = 8,
    parameter int unsigned NUM_CB   = 2,
    parameter int unsigned CB_SEL_W = 1,
    parameter int unsigned ACC_W    = 16
);
    logic [PIXEL_W-1:0]        cur_in;
    logic                      cur_wr_en;
    logic [CB_SEL_W-1:0]       cur_wr_bank;
    logic [CB_SEL_W-1:0]       cb_select;
    logic [PIXEL_W-1:0]        ref_up_1;
    logic [PIXEL_W-1:0]        ref_up_s;
    logic [PIXEL_W-1:0]        ref_dn_1;
    logic [PIXEL_W-1:0]        ref_dn_s;
    logic                      ref_ld;
    logic [1:0]                ref_sel;
    logic                      abs_mask;
    logic                      acc_start;
    logic                      in_valid;
    logic [NUM_CB*PIXEL_W-1:0] next_cur;
    logic [PIXEL_W-1:0]        ref_pix;
    logic [PIXEL_W-1:0]        abs_out;
    logic [ACC_W-1:0]          sad_out;
    logic                      sad_valid;
    logic                      busy;
    logic                      sad_sat;

    modport master (
        output cur_in, cur_wr_en, cur_wr_bank, cb_select,
        output ref_up_1, ref_up_s, ref_dn_1, ref_dn_s, ref_ld, ref_sel,
        output abs_mask, acc_start, in_valid,
        input  next_cur, ref_pix, abs_out, sad_out, sad_valid, busy, sad_sat
    );

    modport slave (
        input  cur_in, cur_wr_en, cur_wr_bank, cb_select,
        input  ref_up_1, ref_up_s, ref_dn_1, ref_dn_s, ref_ld, ref_sel,
        input  abs_mask, acc_start, in_valid,
        output next_cur, ref_pix, abs_out, sad_out, sad_valid, busy, sad_sat
    );
endinterface

// File: rtl/pe_sad_acc.sv
// Motion-estimation PE: current-block banks, reference tap register, |cur-ref| stage and SAD accumulator.
// Define PE_SAD_SAT_EN to make the accumulator saturate (and flag sad_sat) instead of wrapping.
module pe_sad_acc #(
    parameter int unsigned PIXEL_W  = 8,
    parameter int unsigned NUM_CB   = 2,
    parameter int unsigned CB_SEL_W = 1,
    parameter int unsigned BLK_PIX  = 64,
    parameter int unsigned ACC_W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    pe_sad_acc_if.slave  bus
);
    localparam int unsigned DIFF_W = PIXEL_W + 1;
    localparam int unsigned CNT_W  = $clog2(BLK_PIX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_PIX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    logic [PIXEL_W-1:0] bank_q [NUM_CB];
    logic [PIXEL_W-1:0] bank_d [NUM_CB];
    logic [PIXEL_W-1:0] ref_q,  ref_d;
    logic [PIXEL_W-1:0] abs_q,  abs_d;
    logic               abs_v_q, abs_v_d;
    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q,  acc_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;
    logic [ACC_W-1:0]   sad_q,  sad_d;
    logic               sad_valid_q, sad_valid_d;
    logic               sat_q,  sat_d;

    logic [PIXEL_W-1:0] cur_sel;
    logic [DIFF_W-1:0]  diff_w;
    logic [PIXEL_W-1:0] abs_c;
    logic [ACC_W-1:0]   acc_add;
    logic               clip;
    logic [NUM_CB*PIXEL_W-1:0] next_cur_w;

    // Accumulate step: clip at all-ones when saturating, otherwise wrap.
`ifdef PE_SAD_SAT_EN
    logic [ACC_W:0] sum_w;
    assign sum_w   = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(abs_q);
    assign clip    = sum_w[ACC_W];
    assign acc_add = clip ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
`else
    assign clip    = 1'b0;
    assign acc_add = acc_q + ACC_W'(abs_q);
`endif

    // Banks, reference register and the absolute-difference stage.
    always_comb begin
        bank_d = bank_q;
        if (bus.cur_wr_en) begin
            bank_d[bus.cur_wr_bank] = bus.cur_in;
        end

        ref_d = ref_q;
        if (bus.ref_ld) begin
            case (bus.ref_sel)
                2'b00:   ref_d = bus.ref_up_1;
                2'b01:   ref_d = bus.ref_up_s;
                2'b10:   ref_d = bus.ref_dn_1;
                default: ref_d = bus.ref_dn_s;
            endcase
        end

        cur_sel = bank_q[bus.cb_select];
        diff_w  = DIFF_W'(cur_sel) - DIFF_W'(ref_q);
        // Negative result: the low bits' two's complement is the magnitude.
        abs_c   = diff_w[PIXEL_W] ? (PIXEL_W'(0) - diff_w[PIXEL_W-1:0]) : diff_w[PIXEL_W-1:0];

        abs_d   = abs_q;
        abs_v_d = bus.in_valid;
        if (bus.in_valid) begin
            abs_d = bus.abs_mask ? '0 : abs_c;
        end
    end

    // SAD control: restart always wins over a pending difference, including the final one.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sad_d       = sad_q;
        sad_valid_d = 1'b0;
        sat_d       = sat_q;
        case (state_q)
            IDLE: begin
                if (bus.acc_start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            ACCUM: begin
                if (bus.acc_start) begin
                    acc_d = '0;
                    cnt_d = '0;
                    sat_d = 1'b0;
                end else if (abs_v_q) begin
                    if (clip) begin
                        sat_d = 1'b1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        sad_d       = acc_add;
                        sad_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end else begin
                        acc_d = acc_add;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        next_cur_w = '0;
        for (int unsigned i = 0; i < NUM_CB; i++) begin
            next_cur_w[i*PIXEL_W +: PIXEL_W] = bank_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CB; i++) begin
                bank_q[i] <= '0;
            end
            ref_q       <= '0;
            abs_q       <= '0;
            abs_v_q     <= 1'b0;
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sad_q       <= '0;
            sad_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            ref_q       <= ref_d;
            abs_q       <= abs_d;
            abs_v_q     <= abs_v_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sad_q       <= sad_d;
            sad_valid_q <= sad_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign bus.next_cur  = next_cur_w;
    assign bus.ref_pix   = ref_q;
    assign bus.abs_out   = abs_q;
    assign bus.sad_out   = sad_q;
    assign bus.sad_valid = sad_valid_q;
    assign bus.busy      = (state_q == ACCUM);
    assign bus.sad_sat   = sat_q;
endmodule

// File: tb/tb_pe_sad_acc.sv
// Bench for pe_sad_acc (BLK_PIX=4, ACC_W=9): directed tables/sequences plus random traffic vs a reference model.
module tb_pe_sad_acc;
    localparam int PW   = 8;
    localparam int BLK  = 4;
    localparam int AW   = 9;
    localparam int SMAX = (1 << AW) - 1;

    logic clk;
    logic rst;

    pe_sad_acc_if #(.PIXEL_W(PW), .NUM_CB(2), .CB_SEL_W(1), .ACC_W(AW)) bus ();

    pe_sad_acc #(.PIXEL_W(PW), .NUM_CB(2), .CB_SEL_W(1), .BLK_PIX(BLK), .ACC_W(AW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int sv_seen = 0;
    bit model_chk = 1'b0;

    // Reference model: banks, reference pixel, last difference, and the list of differences of the open SAD.
    int m_bank [2];
    int m_ref, m_abs, m_sad;
    bit m_absv, m_busy, m_sv, m_sat;
    int m_q [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bank[0] = 0; m_bank[1] = 0;
        m_ref = 0; m_abs = 0; m_sad = 0;
        m_absv = 0; m_busy = 0; m_sv = 0; m_sat = 0;
        m_q.delete();
    endtask

    function automatic int report(input int tot);
`ifdef PE_SAD_SAT_EN
        return (tot > SMAX) ? SMAX : tot;
`else
        return tot % (SMAX + 1);
`endif
    endfunction

    task automatic idle_inputs();
        bus.cur_in = '0; bus.cur_wr_en = 0; bus.cur_wr_bank = '0; bus.cb_select = '0;
        bus.ref_up_1 = '0; bus.ref_up_s = '0; bus.ref_dn_1 = '0; bus.ref_dn_s = '0;
        bus.ref_ld = 0; bus.ref_sel = '0; bus.abs_mask = 0; bus.acc_start = 0; bus.in_valid = 0;
    endtask

    // One clock: advance the model from the driven inputs, clock, then compare.
    task automatic tick();
        int cs, d, tot;
        cs = m_bank[bus.cb_select];
        d  = (cs > m_ref) ? cs - m_ref : m_ref - cs;
        if (bus.abs_mask) d = 0;
        m_sv = 0;
        if (bus.acc_start) begin
            m_busy = 1; m_sat = 0; m_q.delete();
        end else if (m_busy && m_absv) begin
            m_q.push_back(m_abs);
            tot = 0;
            foreach (m_q[i]) tot += m_q[i];
`ifdef PE_SAD_SAT_EN
            if (tot > SMAX) m_sat = 1;
`endif
            if (m_q.size() == BLK) begin
                m_sad = report(tot); m_sv = 1; m_busy = 0; m_q.delete();
            end
        end
        if (bus.in_valid) m_abs = d;
        m_absv = bus.in_valid;
        if (bus.cur_wr_en) m_bank[bus.cur_wr_bank] = int'(bus.cur_in);
        if (bus.ref_ld) begin
            case (bus.ref_sel)
                2'd0: m_ref = int'(bus.ref_up_1);
                2'd1: m_ref = int'(bus.ref_up_s);
                2'd2: m_ref = int'(bus.ref_dn_1);
                default: m_ref = int'(bus.ref_dn_s);
            endcase
        end
        @(posedge clk);
        #1;
        if (bus.sad_valid) sv_seen++;
        if (model_chk) begin
            chk("m_abs_out",   int'(bus.abs_out),   m_abs);
            chk("m_ref_pix",   int'(bus.ref_pix),   m_ref);
            chk("m_next_cur",  int'(bus.next_cur),  (m_bank[1] << 8) | m_bank[0]);
            chk("m_sad_valid", int'(bus.sad_valid), int'(m_sv));
            chk("m_sad_out",   int'(bus.sad_out),   m_sad);
            chk("m_busy",      int'(bus.busy),      int'(m_busy));
            chk("m_sad_sat",   int'(bus.sad_sat),   int'(m_sat));
        end
    endtask

    task automatic wr_bank(input int b, input int v);
        bus.cur_wr_en = 1; bus.cur_wr_bank = 1'(b); bus.cur_in = 8'(v);
        tick();
        bus.cur_wr_en = 0;
    endtask

    task automatic ld_ref(input int sel, input int tap);
        bus.ref_up_1 = (sel == 0) ? 8'(tap) : 8'hA5;
        bus.ref_up_s = (sel == 1) ? 8'(tap) : 8'hA5;
        bus.ref_dn_1 = (sel == 2) ? 8'(tap) : 8'hA5;
        bus.ref_dn_s = (sel == 3) ? 8'(tap) : 8'hA5;
        bus.ref_ld = 1; bus.ref_sel = 2'(sel);
        tick();
        bus.ref_ld = 0;
    endtask

    task automatic diff(input int cb, input bit mask);
        bus.cb_select = 1'(cb); bus.abs_mask = mask; bus.in_valid = 1;
        tick();
        bus.in_valid = 0; bus.abs_mask = 0;
    endtask

    task automatic start();
        bus.acc_start = 1;
        tick();
        bus.acc_start = 0;
    endtask

    task automatic pix(input int v, input bit mask);
        wr_bank(0, v);
        diff(0, mask);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_abs"},  int'(bus.abs_out),   0);
        chk({tag, "_ref"},  int'(bus.ref_pix),   0);
        chk({tag, "_cur"},  int'(bus.next_cur),  0);
        chk({tag, "_sad"},  int'(bus.sad_out),   0);
        chk({tag, "_sv"},   int'(bus.sad_valid), 0);
        chk({tag, "_busy"}, int'(bus.busy),      0);
        chk({tag, "_sat"},  int'(bus.sad_sat),   0);
    endtask

    typedef struct {
        int c0, c1, sel, rsel, tap;
        int exp_ref, exp_abs;
    } vec_t;

    initial begin
        vec_t tv [6];
        int snap, exp_sad, exp_sat;
        tv[0] = '{8'h0F, 8'h07, 0, 0, 8'h01, 8'h01, 8'h0E};
        tv[1] = '{8'h0F, 8'h07, 1, 0, 8'h01, 8'h01, 8'h06};
        tv[2] = '{8'h0F, 8'h07, 1, 3, 8'h20, 8'h20, 8'h19};
        tv[3] = '{8'h00, 8'hFF, 1, 1, 8'h00, 8'h00, 8'hFF};
        tv[4] = '{8'h80, 8'h00, 0, 2, 8'h81, 8'h81, 8'h01};
        tv[5] = '{8'h44, 8'h10, 0, 1, 8'h44, 8'h44, 8'h00};

        idle_inputs();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        model_chk = 1'b1;

        // Bank/tap selection and absolute difference.
        foreach (tv[i]) begin
            wr_bank(0, tv[i].c0);
            wr_bank(1, tv[i].c1);
            ld_ref(tv[i].rsel, tv[i].tap);
            diff(tv[i].sel, 0);
            chk("tbl_ref_pix", int'(bus.ref_pix), tv[i].exp_ref);
            chk("tbl_abs_out", int'(bus.abs_out), tv[i].exp_abs);
        end

        // Basic SAD 3+5+0+9 with gaps, 2-cycle latency.
        ld_ref(0, 10);
        start();
        chk("sad_busy_start", int'(bus.busy), 1);
        pix(13, 0); pix(15, 0); pix(10, 0); pix(1, 0);
        chk("sad_not_early", int'(bus.sad_valid), 0);
        tick();
        chk("sad_valid", int'(bus.sad_valid), 1);
        chk("sad_17", int'(bus.sad_out), 17);
        chk("sad_busy_drop", int'(bus.busy), 0);
        tick();
        chk("sad_pulse_1cyc", int'(bus.sad_valid), 0);
        chk("sad_hold", int'(bus.sad_out), 17);

        // Restart after 2 pixels (pending difference dropped).
        snap = sv_seen;
        start();
        pix(17, 0); pix(18, 0);
        start();
        pix(11, 0); pix(11, 0); pix(11, 0); pix(11, 0);
        tick();
        chk("restart_sad", int'(bus.sad_out), 4);
        chk("restart_one_valid", sv_seen - snap, 1);

        // All differences masked.
        start();
        pix(8'hF0, 1); pix(8'hF0, 1); pix(8'hF0, 1); pix(8'hF0, 1);
        tick();
        chk("mask_valid", int'(bus.sad_valid), 1);
        chk("mask_sad", int'(bus.sad_out), 0);

        // Restart coinciding with the final difference.
        start();
        pix(12, 0); pix(12, 0); pix(12, 0); pix(12, 0);
        start();
        chk("final_restart_no_valid", int'(bus.sad_valid), 0);
        chk("final_restart_busy", int'(bus.busy), 1);
        pix(13, 0); pix(13, 0); pix(13, 0); pix(13, 0);
        tick();
        chk("final_restart_sad", int'(bus.sad_out), 12);

        // Same-cycle bank write and ref load use old values.
        wr_bank(0, 8'h30);
        ld_ref(0, 8'h10);
        bus.cur_wr_en = 1; bus.cur_wr_bank = 1'b0; bus.cur_in = 8'h50;
        bus.ref_ld = 1; bus.ref_sel = 2'd0; bus.ref_up_1 = 8'h05;
        bus.cb_select = 1'b0; bus.in_valid = 1;
        tick();
        idle_inputs();
        chk("same_cyc_old_abs", int'(bus.abs_out), 8'h20);
        chk("same_cyc_new_ref", int'(bus.ref_pix), 8'h05);
        diff(0, 0);
        chk("same_cyc_next_abs", int'(bus.abs_out), 8'h4B);

        // Overflow: four differences of 255 into a 9-bit accumulator.
`ifdef PE_SAD_SAT_EN
        exp_sad = 511; exp_sat = 1;
`else
        exp_sad = 508; exp_sat = 0;
`endif
        wr_bank(0, 8'hFF);
        ld_ref(0, 0);
        start();
        diff(0, 0); diff(0, 0); diff(0, 0); diff(0, 0);
        tick();
        chk("ovf_sad", int'(bus.sad_out), exp_sad);
        chk("ovf_sat", int'(bus.sad_sat), exp_sat);
        start();
        chk("ovf_sat_clear", int'(bus.sad_sat), 0);

        // Asynchronous reset mid-SAD, then a fresh SAD.
        pix(20, 0); pix(20, 0);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        start();
        pix(3, 0); pix(3, 0); pix(3, 0); pix(3, 0);
        tick();
        chk("post_rst_valid", int'(bus.sad_valid), 1);
        chk("post_rst_sad", int'(bus.sad_out), 12);

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            bus.acc_start   = m_busy ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 4) == 0);
            bus.in_valid    = ($urandom_range(0, 2) != 0);
            bus.abs_mask    = ($urandom_range(0, 7) == 0);
            bus.cb_select   = 1'($urandom_range(0, 1));
            bus.cur_wr_en   = ($urandom_range(0, 1) == 1);
            bus.cur_wr_bank = 1'($urandom_range(0, 1));
            bus.cur_in      = 8'($urandom_range(0, 255));
            bus.ref_ld      = ($urandom_range(0, 2) == 0);
            bus.ref_sel     = 2'($urandom_range(0, 3));
            bus.ref_up_1    = 8'($urandom_range(0, 255));
            bus.ref_up_s    = 8'($urandom_range(0, 255));
            bus.ref_dn_1    = 8'($urandom_range(0, 255));
            bus.ref_dn_s    = 8'($urandom_range(0, 255));
            tick();
        end
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
